// File: rtl/i2s_dac_tx_pkg.sv
// Shared audio definitions for the I2S playback path.
// Channel encoding on DACLRCK, serialiser states, default word width.
package i2s_dac_tx_pkg;

   localparam logic I2S_LEFT = 1'b0;
   localparam logic I2S_RIGHT = 1'b1;
   localparam int I2S_DEF_WIDTH = 16;

   typedef enum logic [1:0] {
      WAIT_LEFT,
      SHIFT,
      PAD
   } tx_state_t;

endpackage

// File: rtl/i2s_stage_buf.sv
// One-deep staging buffer feeding the active L/R pair of the DAC serialiser.
// word_l/word_r expose the pair as it will be after this edge.
module i2s_stage_buf
   import i2s_dac_tx_pkg::*;
#(
   parameter int DATA_WIDTH = I2S_DEF_WIDTH,
   parameter bit MUTE_ON_UNDERRUN = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  left_start,
   input  logic [DATA_WIDTH-1:0] left_in,
   input  logic [DATA_WIDTH-1:0] right_in,
   input  logic                  in_valid,
   input  logic                  clear_flags,
   output logic [DATA_WIDTH-1:0] word_l,
   output logic [DATA_WIDTH-1:0] word_r,
   output logic                  underrun,
   output logic                  overrun
);

   logic [DATA_WIDTH-1:0] stg_l;
   logic [DATA_WIDTH-1:0] stg_r;
   logic [DATA_WIDTH-1:0] act_l;
   logic [DATA_WIDTH-1:0] act_r;
   logic [DATA_WIDTH-1:0] nxt_l;
   logic [DATA_WIDTH-1:0] nxt_r;
   logic                  stage_full;
   logic                  nxt_full;
   logic                  set_ur;
   logic                  set_ov;

   // A left start consumes the stage; an empty stage lets in_valid bypass.
   always_comb begin
      nxt_l = act_l;
      nxt_r = act_r;
      nxt_full = stage_full;
      set_ur = 1'b0;
      set_ov = 1'b0;
      if (left_start) begin
         if (stage_full) begin
            nxt_l = stg_l;
            nxt_r = stg_r;
            nxt_full = in_valid;
         end else if (in_valid) begin
            nxt_l = left_in;
            nxt_r = right_in;
         end else begin
            set_ur = 1'b1;
            if (MUTE_ON_UNDERRUN) begin
               nxt_l = '0;
               nxt_r = '0;
            end
         end
      end else if (in_valid) begin
         nxt_full = 1'b1;
         set_ov = stage_full;
      end
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg_l <= '0;
         stg_r <= '0;
         act_l <= '0;
         act_r <= '0;
         stage_full <= 1'b0;
         underrun <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (in_valid) begin
            stg_l <= left_in;
            stg_r <= right_in;
         end
         act_l <= nxt_l;
         act_r <= nxt_r;
         stage_full <= nxt_full;
         underrun <= set_ur | (underrun & ~clear_flags);
         overrun <= set_ov | (overrun & ~clear_flags);
      end
   end

   assign word_l = nxt_l;
   assign word_r = nxt_r;

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S DAC transmitter: shifts stereo PCM onto DACDAT, MSB first.
// Codec is bus master; all state moves on the BCLK falling edge.
module i2s_dac_tx
   import i2s_dac_tx_pkg::*;
#(
   parameter int DATA_WIDTH = I2S_DEF_WIDTH,
   parameter bit MUTE_ON_UNDERRUN = 1'b1
) (
   input  logic                  BCLK,
   input  logic                  RESET,
   input  logic                  LRCLK,
   input  logic [DATA_WIDTH-1:0] left_in,
   input  logic [DATA_WIDTH-1:0] right_in,
   input  logic                  in_valid,
   input  logic                  clear_flags,
   output logic                  DACDAT,
   output logic                  frame_start,
   output logic                  underrun,
   output logic                  overrun
);

   localparam int CW = $clog2(DATA_WIDTH + 1);

   tx_state_t             state;
   logic                  lr_q;
   logic                  trans;
   logic                  left_start;
   logic [DATA_WIDTH-1:0] word;
   logic [DATA_WIDTH-1:0] word_l;
   logic [DATA_WIDTH-1:0] word_r;
   logic [DATA_WIDTH-1:0] shreg;
   logic [CW-1:0]         bitcnt;

   // lr_q lags LRCLK by one edge, which supplies the I2S one-bit delay.
   assign trans = (LRCLK != lr_q);
   assign left_start = trans && (LRCLK == I2S_LEFT);
   assign word = (LRCLK == I2S_LEFT) ? word_l : word_r;

   i2s_stage_buf #(
      .DATA_WIDTH(DATA_WIDTH),
      .MUTE_ON_UNDERRUN(MUTE_ON_UNDERRUN)
   ) u_stage (
      .clk(BCLK),
      .rst_n(RESET),
      .left_start(left_start),
      .left_in(left_in),
      .right_in(right_in),
      .in_valid(in_valid),
      .clear_flags(clear_flags),
      .word_l(word_l),
      .word_r(word_r),
      .underrun(underrun),
      .overrun(overrun)
   );

   always_ff @(negedge BCLK or negedge RESET) begin
      if (!RESET) begin
         state <= WAIT_LEFT;
         lr_q <= 1'b1;
         DACDAT <= 1'b0;
         frame_start <= 1'b0;
         shreg <= '0;
         bitcnt <= '0;
      end else begin
         lr_q <= LRCLK;
         frame_start <= left_start;
         if (left_start || (trans && state != WAIT_LEFT)) begin
            state <= SHIFT;
            DACDAT <= word[DATA_WIDTH-1];
            shreg <= word << 1;
            bitcnt <= CW'(DATA_WIDTH - 1);
         end else begin
            unique case (state)
               WAIT_LEFT: DACDAT <= 1'b0;
               SHIFT: begin
                  if (bitcnt == '0) begin
                     state <= PAD;
                     DACDAT <= 1'b0;
                  end else begin
                     DACDAT <= shreg[DATA_WIDTH-1];
                     shreg <= shreg << 1;
                     bitcnt <= bitcnt - 1'b1;
                  end
               end
               PAD: DACDAT <= 1'b0;
               default: begin
                  state <= WAIT_LEFT;
                  DACDAT <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Scoreboard bench for i2s_dac_tx: muting and repeating variants side by side.
// Stimulus queues per-cycle expectations; a monitor checks them after each edge.
module tb_i2s_dac_tx;

   logic        BCLK;
   logic        RESET;
   logic        LRCLK;
   logic [15:0] left_in;
   logic [15:0] right_in;
   logic        in_valid;
   logic        clear_flags;
   logic        dat_m, fs_m, ur_m, ov_m;
   logic        dat_h, fs_h, ur_h, ov_h;

   typedef struct {
      logic dat_m;
      logic dat_h;
      logic fs;
      logic ur;
      logic ov;
      int   tag;
   } exp_t;

   exp_t q[$];
   exp_t got;
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc = 0;
   logic staged = 1'b0;
   logic e_ur = 1'b0;
   logic e_ov = 1'b0;

   i2s_dac_tx #(.DATA_WIDTH(16), .MUTE_ON_UNDERRUN(1'b1)) u_mute (
      .BCLK(BCLK), .RESET(RESET), .LRCLK(LRCLK),
      .left_in(left_in), .right_in(right_in),
      .in_valid(in_valid), .clear_flags(clear_flags),
      .DACDAT(dat_m), .frame_start(fs_m),
      .underrun(ur_m), .overrun(ov_m)
   );

   i2s_dac_tx #(.DATA_WIDTH(16), .MUTE_ON_UNDERRUN(1'b0)) u_hold (
      .BCLK(BCLK), .RESET(RESET), .LRCLK(LRCLK),
      .left_in(left_in), .right_in(right_in),
      .in_valid(in_valid), .clear_flags(clear_flags),
      .DACDAT(dat_h), .frame_start(fs_h),
      .underrun(ur_h), .overrun(ov_h)
   );

   initial BCLK = 1'b0;
   always #5 BCLK = ~BCLK;

   task automatic chk(input string name, input logic act,
                      input logic want, input int tag);
      n_vec++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s cyc %0d: got %b want %b", name, tag, act, want);
      end
   endtask

   always @(negedge BCLK) begin
      #1;
      if (q.size() > 0) begin
         got = q.pop_front();
         chk("dacdat_mute", dat_m, got.dat_m, got.tag);
         chk("dacdat_hold", dat_h, got.dat_h, got.tag);
         chk("frame_start_mute", fs_m, got.fs, got.tag);
         chk("frame_start_hold", fs_h, got.fs, got.tag);
         chk("underrun_mute", ur_m, got.ur, got.tag);
         chk("underrun_hold", ur_h, got.ur, got.tag);
         chk("overrun_mute", ov_m, got.ov, got.tag);
         chk("overrun_hold", ov_h, got.ov, got.tag);
      end
   end

   // One channel period of n BCLKs; wm/wh are the words each variant sends.
   task automatic chan(input logic lr, input int n, input logic start,
                       input logic [15:0] wm, input logic [15:0] wh,
                       input int iv1, input logic [15:0] l1,
                       input logic [15:0] r1,
                       input int iv2, input logic [15:0] l2,
                       input logic [15:0] r2,
                       input int clr, input int rlo, input int rhi);
      exp_t e;
      logic iv, su, so, in_rst, dead, live;
      for (int j = 0; j < n; j++) begin
         @(posedge BCLK);
         in_rst = (rlo >= 0) && (j >= rlo) && (j < rhi);
         dead = (rlo >= 0) && (j >= rlo);
         iv = (j == iv1) || (j == iv2);
         LRCLK = lr;
         RESET = ~in_rst;
         in_valid = iv;
         left_in = (j == iv2) ? l2 : l1;
         right_in = (j == iv2) ? r2 : r1;
         clear_flags = (j == clr);
         if (j == rlo) begin
            #1;
            chk("reset_now_mute", dat_m, 1'b0, cyc);
            chk("reset_now_hold", dat_h, 1'b0, cyc);
         end
         su = 1'b0;
         so = 1'b0;
         if (in_rst) begin
            staged = 1'b0;
            e_ur = 1'b0;
            e_ov = 1'b0;
         end else begin
            if (start && j == 0 && lr == 1'b0) begin
               if (staged) staged = iv;
               else if (!iv) su = 1'b1;
            end else if (iv) begin
               so = staged;
               staged = 1'b1;
            end
            if (j == clr) begin
               e_ur = 1'b0;
               e_ov = 1'b0;
            end
            if (su) e_ur = 1'b1;
            if (so) e_ov = 1'b1;
         end
         live = !dead && start && (j < 16);
         e.dat_m = live ? wm[15-j] : 1'b0;
         e.dat_h = live ? wh[15-j] : 1'b0;
         e.fs = !dead && start && (j == 0) && (lr == 1'b0);
         e.ur = e_ur;
         e.ov = e_ov;
         e.tag = cyc;
         cyc++;
         q.push_back(e);
      end
   endtask

   initial begin
      RESET = 1'b1;
      LRCLK = 1'b1;
      left_in = '0;
      right_in = '0;
      in_valid = 1'b0;
      clear_flags = 1'b0;
      // reset, then idle right half with no transition
      chan(1, 4, 0, 0, 0, -1, 0, 0, -1, 0, 0, -1, 0, 4);
      chan(1, 32, 0, 0, 0, -1, 0, 0, -1, 0, 0, -1, -1, 0);
      // empty frames: zeros, frame_start on left, underrun
      chan(0, 32, 1, 0, 0, -1, 0, 0, -1, 0, 0, -1, -1, 0);
      chan(1, 32, 1, 0, 0, -1, 0, 0, -1, 0, 0, -1, -1, 0);
      chan(0, 32, 1, 0, 0, -1, 0, 0, -1, 0, 0, -1, -1, 0);
      // stage a pair and clear the underrun flag
      chan(1, 32, 1, 0, 0, 5, 16'hA5C3, 16'h8001,
           -1, 0, 0, 10, -1, 0);
      chan(0, 32, 1, 16'hA5C3, 16'hA5C3, -1, 0, 0, -1, 0, 0, -1, -1, 0);
      chan(1, 32, 1, 16'h8001, 16'h8001, -1, 0, 0, -1, 0, 0, -1, -1, 0);
      // underrun: mute vs repeat
      chan(0, 32, 1, 0, 16'hA5C3, -1, 0, 0, -1, 0, 0, -1, -1, 0);
      // overrun, with a clear coinciding with the second in_valid
      chan(1, 32, 1, 0, 16'h8001, 3, 16'h1111, 16'h2222,
           10, 16'h3333, 16'h4444, 10, -1, 0);
      chan(0, 32, 1, 16'h3333, 16'h3333, -1, 0, 0, -1, 0, 0, -1, -1, 0);
      chan(1, 32, 1, 16'h4444, 16'h4444, -1, 0, 0, -1, 0, 0, 2, -1, 0);
      // bypass on the left-start edge
      chan(0, 32, 1, 16'h7FFF, 16'h7FFF, 0, 16'h7FFF, 16'h0001,
           -1, 0, 0, -1, -1, 0);
      chan(1, 32, 1, 16'h0001, 16'h0001, 20, 16'h5AC3, 16'hC35A,
           -1, 0, 0, -1, -1, 0);
      // short left channel truncates LSBs
      chan(0, 8, 1, 16'h5AC3, 16'h5AC3, -1, 0, 0, -1, 0, 0, -1, -1, 0);
      chan(1, 32, 1, 16'hC35A, 16'hC35A, -1, 0, 0, -1, 0, 0, -1, -1, 0);
      chan(0, 32, 1, 0, 16'h5AC3, -1, 0, 0, -1, 0, 0, -1, -1, 0);
      // reset mid-word, resume at next left transition
      chan(1, 32, 1, 0, 16'hC35A, 10, 16'h8421, 16'h1248,
           -1, 0, 0, -1, 2, 6);
      chan(0, 32, 1, 16'h8421, 16'h8421, -1, 0, 0, -1, 0, 0, -1, -1, 0);
      chan(1, 32, 1, 16'h1248, 16'h1248, -1, 0, 0, -1, 0, 0, -1, -1, 0);
      repeat (3) @(posedge BCLK);
      if (q.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain: got %0d left want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/i2s_dac_tx.md
Name: i2s_dac_tx

Overview:
- I2S transmitter that serialises stereo PCM words onto the codec DAC data line (AUD_DACDAT). It is the playback counterpart to the existing I2S ADC receiver.
- The codec is bus master: it drives BCLK and DACLRCK, and this block only shifts data.
- Parallel samples enter through a one-deep staging buffer, so the receiver's output can loop straight back to the DAC in the same BCLK domain.

Parameters:
- DATA_WIDTH, 16, bits per channel word; must match the codec word length programmed over I2C.
- MUTE_ON_UNDERRUN, 1, behaviour when no new pair is staged at frame start: 1 = transmit zeros, 0 = repeat the last pair.

Ports:
- BCLK  in  1  bit clock from codec; all flops update on its falling edge.
- RESET  in  1  asynchronous, active-low reset.
- LRCLK  in  1  DACLRCK from codec; 0 = left channel, 1 = right channel.
- left_in  in  DATA_WIDTH  left sample, two's complement.
- right_in  in  DATA_WIDTH  right sample, two's complement.
- in_valid  in  1  one-cycle strobe; left_in/right_in are valid this cycle.
- clear_flags  in  1  synchronous clear of the sticky flags.
- DACDAT  out  1  serial data to codec, MSB first.
- frame_start  out  1  one-cycle pulse on the cycle the left MSB is driven.
- underrun  out  1  sticky; a left frame started with no staged pair.
- overrun  out  1  sticky; in_valid arrived while staging was already full.

Behaviour:
- Single clock is BCLK, falling edge. The codec samples DACDAT on the BCLK rising edge and changes LRCLK just after a falling edge.
- Reset (RESET=0, asynchronous):
  - DACDAT, frame_start, underrun and overrun = 0.
  - stage_full = 0; active pair = 0; lr_q = 1; state = WAIT_LEFT.
- Transition detect:
  - lr_q <= LRCLK on every falling edge.
  - trans = (LRCLK != lr_q). The edge where trans is true is exactly one BCLK after the codec's LRCLK change, which is where the I2S MSB is due. The one-bit I2S delay therefore needs no extra state.
- States:
  - WAIT_LEFT: DACDAT = 0. Go to SHIFT when trans && LRCLK==0. Right-channel transitions are ignored here, so output always starts on a left word.
  - SHIFT: on entry, drive word[DATA_WIDTH-1]; load shreg <= word<<1 and bitcnt <= DATA_WIDTH-1. Each later edge drives shreg MSB, shifts, and decrements bitcnt. When bitcnt reaches 0, go to PAD.
  - PAD: DACDAT = 0 until the next trans, then go to SHIFT.
- Word selection: LRCLK==0 selects act_l; LRCLK==1 selects act_r.
- Any trans in SHIFT or PAD restarts SHIFT immediately. A short frame (fewer BCLKs than DATA_WIDTH) truncates the LSBs silently.
- Left-frame start (trans && LRCLK==0):
  - If stage_full: act <= stage, stage_full <= 0, and the MSB driven is the newly loaded left word.
  - Else: underrun <= 1. Act becomes 0 if MUTE_ON_UNDERRUN, otherwise keeps its value.
  - frame_start = 1 for this cycle only.
- Right-frame start never reloads act, so the L/R pair stays coherent.
- Staging:
  - in_valid loads stage <= {left_in, right_in} and sets stage_full <= 1.
  - If stage_full is already 1 and this is not a left-start edge, the stage is overwritten and overrun <= 1.
  - If in_valid coincides with a left-start edge and stage_full==0, the pair bypasses staging straight into act. It is transmitted this frame; stage_full stays 0 and no underrun is raised.
  - If in_valid coincides with a left-start edge and stage_full==1, act takes the old stage, stage takes the new data, and stage_full stays 1 with no overrun.
- clear_flags zeroes underrun and overrun. Setting a flag in the same cycle as a clear wins.
- Reset mid-word forces DACDAT to 0 at once. After release, transmission resumes only at the next left transition.

Decomposition:
- Shared audio package: I2S_LEFT=0 / I2S_RIGHT=1 constants, the state enum {WAIT_LEFT, SHIFT, PAD}, and the default word width 16.
- One natural sub-module, i2s_stage_buf: stage register, stage_full, overrun logic and act load, with left_start as an input.
- Serialiser and state machine stay in i2s_dac_tx.

Test Plan:
- Common setup: DATA_WIDTH=16, 32 BCLK per channel.
- Reset, then LRCLK toggling with no in_valid -> DACDAT=0 throughout, and frame_start pulses at each left MSB.
- Normal pair: stage L=16'hA5C3, R=16'h8001 before a left start -> the bits after the left transition read A5C3, then 16 zeros. After the right transition: 1000000000000001. frame_start is high only on the left MSB cycle.
- Underrun: no stage for one frame, MUTE_ON_UNDERRUN=1 -> zeros for both channels, underrun=1 held until clear_flags, then 0.
- Same underrun with MUTE_ON_UNDERRUN=0 -> the previous pair A5C3/8001 is repeated.
- Overrun and clear_flags: two in_valid (1111/2222, then 3333/4444) before a left start -> 3333/4444 transmitted, overrun=1. clear_flags asserted together with a new overrun -> overrun stays 1.
- Bypass and abort:
  - in_valid=1 exactly on the left-start edge with stage empty (L=7FFF) -> MSB=0 then fifteen 1s in that frame, underrun stays 0.
  - Shorten a channel to 8 BCLKs -> only the top 8 bits are sent, then the next channel starts cleanly.
  - RESET pulsed mid-word -> DACDAT=0 immediately, and output restarts only at the next left transition.
